// File: rtl/program_loader.sv
// Front-panel program loader for the SAP computer: debounces the write key,
// drives single-cycle RAM write strobes and holds the CPU until run mode.
module program_loader #(
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              prog_run,
  input  logic              write_key,
  input  logic              auto_inc,
  input  logic [ADDR_W-1:0] switch_enderecos,
  input  logic [DATA_W-1:0] switch_dados,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic [ADDR_W:0]   load_count,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HANDOFF_END = CNT_W'(1);
  localparam logic [ADDR_W:0]  LOAD_MAX    = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    PROG_IDLE  = 3'd0,
    PRESS_DB   = 3'd1,
    COMMIT     = 3'd2,
    RELEASE_DB = 3'd3,
    HANDOFF    = 3'd4,
    RUN        = 3'd5
  } state_t;

  // Valid/ready does not apply here: ram_we is a one-cycle strobe with
  // ram_addr/ram_data already stable; the RAM has no way to stall it.

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              prog_s1_q, prog_s2_q;
  logic              key_s1_q, key_s2_q;
  logic              prog_sync, key_low;

  assign prog_sync = prog_s2_q;
  assign key_low   = ~key_s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      PROG_IDLE: begin
        if (prog_sync) begin
          state_d = HANDOFF;
          cnt_d   = '0;
        end else if (key_low) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (prog_sync) begin
          state_d = HANDOFF;
          cnt_d   = '0;
        end else if (!key_low) begin
          state_d = PROG_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
          data_d  = switch_dados;
          addr_d  = auto_inc ? ptr_q : switch_enderecos;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        // The write always completes; a pending mode switch is honoured after it.
        if (auto_inc) ptr_d = ptr_q + ADDR_W'(1);
        if (count_q != LOAD_MAX) count_d = count_q + (ADDR_W+1)'(1);
        cnt_d   = '0;
        state_d = prog_sync ? HANDOFF : RELEASE_DB;
      end
      RELEASE_DB: begin
        if (prog_sync) begin
          state_d = HANDOFF;
          cnt_d   = '0;
        end else if (key_low) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PROG_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HANDOFF: begin
        if (!prog_sync) begin
          state_d = PROG_IDLE;
          ptr_d   = '0;
          count_d = '0;
        end else if (cnt_q == HANDOFF_END) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!prog_sync) begin
          state_d = PROG_IDLE;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = PROG_IDLE;
      end
    endcase
    we_d   = (state_d == COMMIT);
    busy_d = (state_d == PRESS_DB) || (state_d == COMMIT);
    hold_d = (state_d != RUN);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= PROG_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      hold_q    <= 1'b1;
      busy_q    <= 1'b0;
      count_q   <= '0;
      prog_s1_q <= 1'b0;
      prog_s2_q <= 1'b0;
      key_s1_q  <= 1'b1;
      key_s2_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      prog_s1_q <= prog_run;
      prog_s2_q <= prog_s1_q;
      key_s1_q  <= write_key;
      key_s2_q  <= key_s1_q;
    end
  end

  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign ram_we     = we_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign load_count = count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a behavioural loader model drives per-cycle
// checks, directed scenarios pin timing and data with literal values.
module tb_program_loader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int D      = 4;

  logic              clock = 1'b0;
  logic              clear;
  logic              prog_run;
  logic              write_key;
  logic              auto_inc;
  logic [ADDR_W-1:0] switch_enderecos;
  logic [DATA_W-1:0] switch_dados;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic              cpu_hold;
  logic              busy;
  logic [ADDR_W:0]   load_count;
  logic [2:0]        state_dbg;

  int total = 0;
  int bad   = 0;

  program_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock),
    .clear(clear),
    .prog_run(prog_run),
    .write_key(write_key),
    .auto_inc(auto_inc),
    .switch_enderecos(switch_enderecos),
    .switch_dados(switch_dados),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_we(ram_we),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .load_count(load_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: run lengths of synchronised key samples and a mode flag
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  bit              m_k1 = 1'b1, m_k2 = 1'b1, m_p1 = 1'b0, m_p2 = 1'b0;
  bit              m_commit = 1'b0, m_wait_release = 1'b0;
  bit              m_leaving = 1'b0, m_run = 1'b0;
  int              m_low_run = 0, m_high_run = 0, m_handoff_left = 0;
  int              m_loads = 0;
  bit [ADDR_W-1:0] m_ptr = '0;
  bit [ADDR_W-1:0] m_addr = '0;
  bit [DATA_W-1:0] m_data = '0;
  bit              e_we = 1'b0, e_busy = 1'b0, e_hold = 1'b1;

  task automatic model_reset();
    m_k1 = 1'b1; m_k2 = 1'b1; m_p1 = 1'b0; m_p2 = 1'b0;
    m_commit = 1'b0; m_wait_release = 1'b0; m_leaving = 1'b0; m_run = 1'b0;
    m_low_run = 0; m_high_run = 0; m_handoff_left = 0; m_loads = 0;
    m_ptr = '0; m_addr = '0; m_data = '0;
    e_we = 1'b0; e_busy = 1'b0; e_hold = 1'b1;
    exp_q.delete();
  endtask

  task automatic go_leave();
    m_leaving = 1'b1; m_handoff_left = 2; m_low_run = 0; m_wait_release = 1'b0;
  endtask

  task automatic back_to_prog();
    m_run = 1'b0; m_leaving = 1'b0; m_ptr = '0; m_loads = 0;
    m_low_run = 0; m_wait_release = 1'b0;
  endtask

  task automatic model_step();
    bit key_low, prog;
    key_low = !m_k2;
    prog    = m_p2;
    m_k2 = m_k1; m_k1 = write_key;
    m_p2 = m_p1; m_p1 = prog_run;
    if (m_commit) begin
      m_commit = 1'b0;
      if (auto_inc) m_ptr = m_ptr + 1'b1;
      if (m_loads < (1 << ADDR_W)) m_loads++;
      if (prog) go_leave();
      else begin m_wait_release = 1'b1; m_high_run = 0; end
    end else if (m_run || m_leaving) begin
      if (!prog) back_to_prog();
      else if (m_leaving) begin
        m_handoff_left--;
        if (m_handoff_left == 0) begin m_leaving = 1'b0; m_run = 1'b1; end
      end
    end else if (prog) begin
      go_leave();
    end else if (m_wait_release) begin
      if (key_low) m_high_run = 0; else m_high_run++;
      if (m_high_run == D) begin m_wait_release = 1'b0; m_low_run = 0; end
    end else begin
      if (key_low) m_low_run++; else m_low_run = 0;
      if (m_low_run == D + 1) begin
        m_commit = 1'b1;
        m_addr   = auto_inc ? m_ptr : switch_enderecos;
        m_data   = switch_dados;
        exp_q.push_back({m_addr, m_data});
      end
    end
    e_we   = m_commit;
    e_hold = !m_run;
    e_busy = m_commit || (!m_wait_release && !m_leaving && !m_run && m_low_run > 0);
  endtask

  initial forever begin
    @(posedge clock or negedge clear);
    if (!clear) model_reset();
    else model_step();
  end

  // scoreboard / compare process
  int              we_count = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;

  initial forever begin
    @(negedge clock);
    if (clear) begin
      check("ram_we", 32'(ram_we), 32'(e_we));
      check("cpu_hold", 32'(cpu_hold), 32'(e_hold));
      check("busy", 32'(busy), 32'(e_busy));
      check("load_count", 32'(load_count), 32'(m_loads));
      check("ram_addr", 32'(ram_addr), 32'(m_addr));
      check("ram_data", 32'(ram_data), 32'(m_data));
      check("we_while_running", 32'(ram_we & ~cpu_hold), 32'(0));
      if (ram_we) begin
        we_count++;
        last_addr = ram_addr;
        last_data = ram_data;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL write_queue: got write %0h:%0h expected no write", ram_addr, ram_data);
        end else begin
          check("write_addr_data", 32'({ram_addr, ram_data}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int low_n, input int high_n);
    write_key = 1'b0;
    cycles(low_n);
    write_key = 1'b1;
    cycles(high_n);
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got still running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int base;
    int first_seen;
    int edge_at;
    bit saw_handoff;
    bit saw_run;
    bit got;

    clear = 1'b0; prog_run = 1'b0; write_key = 1'b1; auto_inc = 1'b0;
    switch_enderecos = '0; switch_dados = '0;
    cycles(3);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_data", 32'(ram_data), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_load_count", 32'(load_count), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    clear = 1'b1;
    cycles(3);

    // manual write: key held low 10 cycles
    switch_enderecos = 4'h9; switch_dados = 8'hA5;
    base = we_count; first_seen = -1;
    write_key = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (ram_we && first_seen < 0) first_seen = i;
    end
    write_key = 1'b1;
    cycles(10);
    check("manual_latency", 32'(first_seen), 32'd7);
    check("manual_writes", 32'(we_count - base), 32'd1);
    check("manual_addr", 32'(last_addr), 32'h9);
    check("manual_data", 32'(last_data), 32'hA5);
    check("manual_count", 32'(load_count), 32'd1);
    check("manual_hold", 32'(cpu_hold), 32'd1);

    // bounce rejection then a clean press
    switch_enderecos = 4'h3; switch_dados = 8'h3C;
    base = we_count;
    for (int i = 0; i < 5; i++) begin
      write_key = 1'b0; cycles(2);
      write_key = 1'b1; cycles(2);
    end
    check("bounce_no_write", 32'(we_count - base), 32'd0);
    press(10, 10);
    check("bounce_one_write", 32'(we_count - base), 32'd1);
    check("bounce_addr", 32'(last_addr), 32'h3);
    check("bounce_data", 32'(last_data), 32'h3C);

    // third write, then handoff to run
    switch_enderecos = 4'h5; switch_dados = 8'h77;
    press(8, 10);
    check("pre_handoff_count", 32'(load_count), 32'd3);
    prog_run = 1'b1;
    edge_at = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (!cpu_hold && edge_at < 0) edge_at = i;
    end
    check("hold_fall_latency", 32'(edge_at), 32'd5);
    check("run_state", 32'(state_dbg), 32'd5);
    base = we_count;
    press(10, 10);
    check("run_ignores_key", 32'(we_count - base), 32'd0);
    prog_run = 1'b0;
    edge_at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (cpu_hold && edge_at < 0) edge_at = i;
    end
    check("hold_rise_latency", 32'(edge_at), 32'd3);
    check("back_count_clear", 32'(load_count), 32'd0);
    cycles(4);

    // auto-increment with wrap and count saturation
    auto_inc = 1'b1;
    base = we_count;
    for (int i = 0; i < 17; i++) begin
      switch_dados = 8'(i);
      switch_enderecos = 4'(15 - (i % 16));
      press(6, 8);
      if (i == 15) check("auto_addr_15", 32'(last_addr), 32'hF);
    end
    check("auto_writes", 32'(we_count - base), 32'd17);
    check("auto_wrap_addr", 32'(last_addr), 32'h0);
    check("auto_wrap_data", 32'(last_data), 32'h10);
    check("auto_count_sat", 32'(load_count), 32'd16);
    auto_inc = 1'b0;

    // abort: mode switch while the press is still being debounced
    base = we_count; saw_handoff = 1'b0; saw_run = 1'b0;
    write_key = 1'b0;
    cycles(3);
    prog_run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (state_dbg == 3'd4) saw_handoff = 1'b1;
      if (state_dbg == 3'd5) saw_run = 1'b1;
    end
    check("abort_no_write", 32'(we_count - base), 32'd0);
    check("abort_handoff", 32'(saw_handoff), 32'd1);
    check("abort_run", 32'(saw_run), 32'd1);
    check("abort_hold", 32'(cpu_hold), 32'd0);
    write_key = 1'b1;
    prog_run = 1'b0;
    cycles(10);

    // asynchronous reset during the commit cycle
    switch_enderecos = 4'hA; switch_dados = 8'h5A;
    got = 1'b0;
    write_key = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ram_we) begin
        got = 1'b1;
        break;
      end
    end
    check("commit_reached", 32'(got), 32'd1);
    #1 clear = 1'b0;
    #1;
    check("async_we", 32'(ram_we), 32'd0);
    check("async_hold", 32'(cpu_hold), 32'd1);
    check("async_addr", 32'(ram_addr), 32'd0);
    check("async_data", 32'(ram_data), 32'd0);
    check("async_count", 32'(load_count), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clock);
    write_key = 1'b1;
    cycles(3);
    clear = 1'b1;
    cycles(1);
    check("after_reset_state", 32'(state_dbg), 32'd0);
    cycles(5);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
